// File: rtl/multiply_tokens.sv
// Serial token multiplier: every input token on a becomes FACTOR tokens on b.
// Tokens that cannot be emitted at once wait in a saturating backlog counter.
module multiply_tokens #(
  parameter int FACTOR = 2,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             b,
  output logic [CNT_W-1:0] pending,
  output logic             idle,
  output logic             overflow
);

  // Wide enough that c + FACTOR never wraps before the saturation compare
  localparam int W = CNT_W + $clog2(FACTOR + 1) + 1;
  localparam logic [W-1:0] MAXP = W'((1 << CNT_W) - 1);
  localparam logic [W-1:0] ADD  = W'(FACTOR);

  logic [CNT_W-1:0] c;
  logic             ovf;
  logic [W-1:0]     nxt;

  assign b        = !rst && (a || (c != '0));
  assign idle     = (c == '0) && !a;
  assign pending  = c;
  assign overflow = ovf;

  always_comb begin
    nxt = {{(W-CNT_W){1'b0}}, c} + (a ? ADD : '0) - (b ? W'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c   <= '0;
      ovf <= 1'b0;
    end else if (nxt > MAXP) begin
      c   <= MAXP[CNT_W-1:0];
      ovf <= 1'b1;
    end else begin
      c   <= nxt[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_multiply_tokens.sv
// Bench for multiply_tokens: three instances (FACTOR 1, 2, 3) driven by
// directed scenarios and a random stream checked against an owed-token model.
module tb_multiply_tokens;

  localparam int MAXP = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b0, a1 = 1'b0, b1, i1, o1;
  logic       rst2 = 1'b0, a2 = 1'b0, b2, i2, o2;
  logic       rst3 = 1'b0, a3 = 1'b0, b3, i3, o3;
  logic [3:0] p1, p2, p3;

  int checks = 0;
  int errors = 0;

  bit pat_a [2][6] = '{'{1,1,0,0,0,0}, '{1,0,1,0,0,0}};
  bit pat_b [2][6] = '{'{1,1,1,1,0,0}, '{1,1,1,1,0,0}};
  int pat_p [2][6] = '{'{1,2,1,0,0,0}, '{1,0,1,0,0,0}};

  multiply_tokens #(.FACTOR(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .pending(p1), .idle(i1), .overflow(o1));
  multiply_tokens #(.FACTOR(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .a(a2), .b(b2), .pending(p2), .idle(i2), .overflow(o2));
  multiply_tokens #(.FACTOR(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst3), .a(a3), .b(b3), .pending(p3), .idle(i3), .overflow(o3));

  // Reference: tokens owed so far, clamped at the backlog limit
  task automatic model_step(input int f, input bit ain, inout int owed,
                            inout bit lost, output bit bout);
    int total;
    bout  = ain || (owed > 0);
    total = owed + (ain ? f : 0) - (bout ? 1 : 0);
    if (total > MAXP) begin
      lost  = 1'b1;
      total = MAXP;
    end
    owed = total;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst1 = 1; rst2 = 1; rst3 = 1; a1 = 1; a2 = 1; a3 = 1;
    #1;
    checks++; if (b1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_b1 got=%b exp=0", b1); end
    checks++; if (b2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_b2 got=%b exp=0", b2); end
    checks++; if (b3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_b3 got=%b exp=0", b3); end
    @(negedge clk);
    a1 = 0; a2 = 0; a3 = 0;
    @(posedge clk); #1;
    checks++; if (p2 !== 4'd0) begin errors++; $display("[TB] FAIL reset_pending2 got=%0d exp=0", p2); end
    checks++; if (o2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow2 got=%b exp=0", o2); end
    checks++; if (i2 !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle2 got=%b exp=1", i2); end
    checks++; if (p3 !== 4'd0) begin errors++; $display("[TB] FAIL reset_pending3 got=%0d exp=0", p3); end
    checks++; if (o3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow3 got=%b exp=0", o3); end
    checks++; if (p1 !== 4'd0) begin errors++; $display("[TB] FAIL reset_pending1 got=%0d exp=0", p1); end
    @(negedge clk);
    rst1 = 0; rst2 = 0; rst3 = 0;
  endtask

  task automatic test_pattern_f2();
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        a2 = pat_a[t][k];
        #1;
        checks++;
        if (b2 !== pat_b[t][k]) begin
          errors++; $display("[TB] FAIL pat%0d_b[%0d] got=%b exp=%b", t, k, b2, pat_b[t][k]);
        end
        @(posedge clk); #1;
        checks++;
        if (p2 !== 4'(pat_p[t][k])) begin
          errors++; $display("[TB] FAIL pat%0d_pending[%0d] got=%0d exp=%0d", t, k, p2, pat_p[t][k]);
        end
        checks++;
        if (o2 !== 1'b0) begin
          errors++; $display("[TB] FAIL pat%0d_overflow[%0d] got=%b exp=0", t, k, o2);
        end
      end
    end
  endtask

  task automatic test_f3_single();
    bit eb [4] = '{1, 1, 1, 0};
    int ep [4] = '{2, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a3 = (k == 0);
      #1;
      checks++;
      if (b3 !== eb[k]) begin errors++; $display("[TB] FAIL f3_single_b[%0d] got=%b exp=%b", k, b3, eb[k]); end
      @(posedge clk); #1;
      checks++;
      if (p3 !== 4'(ep[k])) begin errors++; $display("[TB] FAIL f3_single_pending[%0d] got=%0d exp=%0d", k, p3, ep[k]); end
    end
  endtask

  task automatic test_f3_random();
    int  owed = 0;
    bit  lost = 0;
    bit  ain, bexp, iexp;
    int  in_ones = 0;
    int  out_ones = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ain = (owed <= 6) && ($urandom_range(0, 2) == 0);
      a3  = ain;
      #1;
      iexp = (owed == 0) && !ain;
      model_step(3, ain, owed, lost, bexp);
      if (ain) in_ones++;
      if (b3 === 1'b1) out_ones++;
      checks++;
      if (b3 !== bexp) begin errors++; $display("[TB] FAIL f3_rand_b[%0d] got=%b exp=%b", k, b3, bexp); end
      checks++;
      if (i3 !== iexp) begin errors++; $display("[TB] FAIL f3_rand_idle[%0d] got=%b exp=%b", k, i3, iexp); end
      @(posedge clk); #1;
      checks++;
      if (p3 !== 4'(owed)) begin errors++; $display("[TB] FAIL f3_rand_pending[%0d] got=%0d exp=%0d", k, p3, owed); end
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a3 = 0;
      #1;
      if (b3 === 1'b1) out_ones++;
    end
    checks++;
    if (i3 !== 1'b1) begin errors++; $display("[TB] FAIL f3_rand_drained got=%b exp=1", i3); end
    checks++;
    if (out_ones != 3 * in_ones) begin
      errors++; $display("[TB] FAIL f3_conservation got=%0d exp=%0d", out_ones, 3 * in_ones);
    end
    checks++;
    if (o3 !== 1'b0) begin errors++; $display("[TB] FAIL f3_rand_overflow got=%b exp=0", o3); end
  endtask

  task automatic test_overflow();
    int run = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      a2 = 1;
      #1;
      if (b2 === 1'b1) run++;
      @(posedge clk); #1;
      checks++;
      if (p2 !== 4'((k < 16) ? k : 15)) begin
        errors++; $display("[TB] FAIL ovf_pending[%0d] got=%0d exp=%0d", k, p2, (k < 16) ? k : 15);
      end
      checks++;
      if (o2 !== (k == 16)) begin
        errors++; $display("[TB] FAIL ovf_flag[%0d] got=%b exp=%b", k, o2, (k == 16));
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a2 = 0;
      #1;
      checks++;
      if (b2 !== (k < 15)) begin
        errors++; $display("[TB] FAIL ovf_drain_b[%0d] got=%b exp=%b", k, b2, (k < 15));
      end
      if (b2 === 1'b1) run++;
    end
    checks++;
    if (run != 31) begin errors++; $display("[TB] FAIL ovf_token_run got=%0d exp=31", run); end
    checks++;
    if (o2 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got=%b exp=1", o2); end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a2 = 1;
      @(posedge clk);
    end
    #1;
    checks++;
    if (p2 !== 4'd5) begin errors++; $display("[TB] FAIL midrst_setup got=%0d exp=5", p2); end
    @(negedge clk);
    a2 = 0; rst2 = 1;
    #1;
    checks++;
    if (b2 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_b got=%b exp=0", b2); end
    @(posedge clk); #1;
    checks++;
    if (p2 !== 4'd0) begin errors++; $display("[TB] FAIL midrst_pending got=%0d exp=0", p2); end
    checks++;
    if (o2 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_overflow got=%b exp=0", o2); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst2 = 0;
      a2 = (k == 0);
      #1;
      checks++;
      if (b2 !== (k < 2)) begin errors++; $display("[TB] FAIL midrst_after_b[%0d] got=%b exp=%b", k, b2, (k < 2)); end
      @(posedge clk);
    end
    #1;
    checks++;
    if (i2 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle got=%b exp=1", i2); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    a2 = 1;
    @(posedge clk); #1;
    checks++;
    if (p2 !== 4'd1) begin errors++; $display("[TB] FAIL simul_setup got=%0d exp=1", p2); end
    @(negedge clk);
    a2 = 1;
    #1;
    checks++;
    if (b2 !== 1'b1) begin errors++; $display("[TB] FAIL simul_b got=%b exp=1", b2); end
    @(posedge clk); #1;
    checks++;
    if (p2 !== 4'd2) begin errors++; $display("[TB] FAIL simul_pending got=%0d exp=2", p2); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a2 = 0;
      @(posedge clk);
    end
    #1;
    checks++;
    if (p2 !== 4'd0) begin errors++; $display("[TB] FAIL simul_drain got=%0d exp=0", p2); end
  endtask

  task automatic test_factor1();
    bit ain;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ain = ($urandom_range(0, 1) == 1);
      a1  = ain;
      #1;
      checks++;
      if (b1 !== ain) begin errors++; $display("[TB] FAIL f1_b[%0d] got=%b exp=%b", k, b1, ain); end
      checks++;
      if (i1 !== !ain) begin errors++; $display("[TB] FAIL f1_idle[%0d] got=%b exp=%b", k, i1, !ain); end
      @(posedge clk); #1;
      checks++;
      if (p1 !== 4'd0) begin errors++; $display("[TB] FAIL f1_pending[%0d] got=%0d exp=0", k, p1); end
      checks++;
      if (o1 !== 1'b0) begin errors++; $display("[TB] FAIL f1_overflow[%0d] got=%b exp=0", k, o1); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_pattern_f2();
    test_f3_single();
    test_f3_random();
    test_overflow();
    test_reset_mid_drain();
    test_simultaneous();
    test_factor1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
